// File: rtl/memory_arbiter_pkg.sv
// ============================================================================
// memory_arbiter_pkg
// Shared types and constants for the instruction/data memory port arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        INSTR_WAIT = 2'd1,
        DATA_WAIT  = 2'd2,
        RESPOND    = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_INSTR = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    localparam int c_burst_cnt_width = 4;

endpackage

`default_nettype wire

// File: rtl/arbiter_burst_counter.sv
// ============================================================================
// arbiter_burst_counter
// Saturating count of consecutive contested data grants.
// Revision: 1.0
// ============================================================================
`default_nettype none

module arbiter_burst_counter
    import memory_arbiter_pkg::*;
#(
    parameter int MAX_COUNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_incr,
    output logic o_saturated
);

    localparam logic [c_burst_cnt_width-1:0] c_max_count = c_burst_cnt_width'(MAX_COUNT);

    logic [c_burst_cnt_width-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_incr && (r_count != c_max_count)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_saturated = (r_count == c_max_count);

endmodule

`default_nettype wire

// File: rtl/memory_port_arbiter.sv
// ============================================================================
// memory_port_arbiter
// Serialises fetch and load/store accesses onto one single-port memory.
// Optional fetch starvation guard: define ARBITER_STARVATION_GUARD_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module memory_port_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instructionRequest,
    input  logic [ADDR_WIDTH-1:0] instructionAddress,
    input  logic                  instructionFlush,
    output logic                  instructionSuccess,
    output logic [DATA_WIDTH-1:0] instructionData,
    input  logic                  dataRead,
    input  logic                  dataWrite,
    input  logic [ADDR_WIDTH-1:0] dataAddress,
    input  logic [DATA_WIDTH-1:0] dataWriteData,
    output logic                  dataDone,
    output logic [DATA_WIDTH-1:0] dataReadData,
    output logic                  memRequest,
    output logic                  memWriteEnable,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [DATA_WIDTH-1:0] memWriteData,
    input  logic                  memReady,
    input  logic [DATA_WIDTH-1:0] memReadData
);

    if ((MAX_DATA_BURST < 1) || (MAX_DATA_BURST > 15)) begin : g_burst_range_check
        $error("MAX_DATA_BURST must be in 1..15");
    end

    state_t r_state;
    state_t w_state_next;
    grant_t r_owner;
    logic   r_drop;

    logic w_data_req;
    logic w_fetch_req;
    logic w_grant_data;
    logic w_grant_instr;
    logic w_burst_sat;
    logic w_mem_done;
    logic w_fetch_phase;

    assign w_data_req    = dataRead | dataWrite;
    assign w_fetch_req   = instructionRequest;
    assign w_grant_data  = (r_state == IDLE) && w_data_req && !(w_fetch_req && w_burst_sat);
    assign w_grant_instr = (r_state == IDLE) && w_fetch_req && !w_grant_data;
    assign w_mem_done    = ((r_state == INSTR_WAIT) || (r_state == DATA_WAIT)) && memReady;
    assign w_fetch_phase = (r_state == INSTR_WAIT) ||
                           ((r_state == RESPOND) && (r_owner == GRANT_INSTR));

`ifdef ARBITER_STARVATION_GUARD_EN
    logic w_cnt_clear;
    logic w_cnt_incr;

    assign w_cnt_incr  = w_grant_data && w_fetch_req;
    assign w_cnt_clear = w_grant_instr || (w_grant_data && !w_fetch_req);

    arbiter_burst_counter #(
        .MAX_COUNT (MAX_DATA_BURST)
    ) u_burst_counter (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_cnt_clear),
        .i_incr      (w_cnt_incr),
        .o_saturated (w_burst_sat)
    );
`else
    assign w_burst_sat = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_data) begin
                    w_state_next = DATA_WAIT;
                end else if (w_grant_instr) begin
                    w_state_next = INSTR_WAIT;
                end
            end
            INSTR_WAIT, DATA_WAIT: begin
                if (memReady) begin
                    w_state_next = RESPOND;
                end
            end
            RESPOND: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Request fields are latched at grant so backend outputs stay stable while memRequest is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner            <= GRANT_INSTR;
            r_drop             <= 1'b0;
            memRequest         <= 1'b0;
            memWriteEnable     <= 1'b0;
            memAddress         <= '0;
            memWriteData       <= '0;
            instructionSuccess <= 1'b0;
            instructionData    <= '0;
            dataDone           <= 1'b0;
            dataReadData       <= '0;
        end else begin
            instructionSuccess <= 1'b0;
            dataDone           <= 1'b0;

            if (w_grant_data) begin
                r_owner        <= GRANT_DATA;
                memRequest     <= 1'b1;
                memWriteEnable <= dataWrite;
                memAddress     <= dataAddress;
                memWriteData   <= dataWriteData;
            end else if (w_grant_instr) begin
                r_owner        <= GRANT_INSTR;
                r_drop         <= 1'b0;
                memRequest     <= 1'b1;
                memWriteEnable <= 1'b0;
                memAddress     <= instructionAddress;
            end

            if (w_fetch_phase && instructionFlush) begin
                r_drop <= 1'b1;
            end

            if (w_mem_done) begin
                memRequest     <= 1'b0;
                memWriteEnable <= 1'b0;
                if (r_owner == GRANT_DATA) begin
                    dataDone <= 1'b1;
                    if (!memWriteEnable) begin
                        dataReadData <= memReadData;
                    end
                end else if (!(r_drop || instructionFlush)) begin
                    instructionSuccess <= 1'b1;
                    instructionData    <= memReadData;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_memory_port_arbiter.sv
// ============================================================================
// tb_memory_port_arbiter
// Scoreboard bench: stimulus pushes expected completions, a monitor pops them.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_memory_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instructionRequest = 1'b0;
    logic [31:0] instructionAddress = '0;
    logic        instructionFlush = 1'b0;
    logic        instructionSuccess;
    logic [31:0] instructionData;
    logic        dataRead = 1'b0;
    logic        dataWrite = 1'b0;
    logic [31:0] dataAddress = '0;
    logic [31:0] dataWriteData = '0;
    logic        dataDone;
    logic [31:0] dataReadData;
    logic        memRequest;
    logic        memWriteEnable;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memReady = 1'b0;
    logic [31:0] memReadData = '0;

    memory_port_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .MAX_DATA_BURST (2)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .instructionRequest (instructionRequest),
        .instructionAddress (instructionAddress),
        .instructionFlush   (instructionFlush),
        .instructionSuccess (instructionSuccess),
        .instructionData    (instructionData),
        .dataRead           (dataRead),
        .dataWrite          (dataWrite),
        .dataAddress        (dataAddress),
        .dataWriteData      (dataWriteData),
        .dataDone           (dataDone),
        .dataReadData       (dataReadData),
        .memRequest         (memRequest),
        .memWriteEnable     (memWriteEnable),
        .memAddress         (memAddress),
        .memWriteData       (memWriteData),
        .memReady           (memReady),
        .memReadData        (memReadData)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        is_data;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    logic [31:0] mem [logic [31:0]];
    int          wait_cycles = 0;
    int          bk_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push_exp(input logic is_data, input logic [31:0] v);
        exp_t e;
        e.is_data = is_data;
        e.val     = v;
        sb.push_back(e);
    endfunction

    // Backend: answers memRequest after wait_cycles idle cycles.
    always @(negedge clk) begin
        if (memRequest && !memReady) begin
            if (bk_cnt >= wait_cycles) begin
                memReady    = 1'b1;
                memReadData = mem.exists(memAddress) ? mem[memAddress] : 32'h0;
                if (memWriteEnable) mem[memAddress] = memWriteData;
                bk_cnt = 0;
            end else begin
                bk_cnt++;
            end
        end else begin
            memReady    = 1'b0;
            memReadData = 32'h0;
            bk_cnt      = 0;
        end
    end

    always @(negedge clk) begin
        if (instructionSuccess || dataDone) begin
            total++;
            if (instructionSuccess && dataDone) begin
                bad++;
                $display("FAIL sb_both_pulses: got both done pulses expected one");
            end else if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got %s pulse expected none",
                         dataDone ? "data" : "instr");
            end else begin
                mon_e = sb.pop_front();
                if ((mon_e.is_data !== dataDone) ||
                    (mon_e.val !== (dataDone ? dataReadData : instructionData))) begin
                    bad++;
                    $display("FAIL sb_completion: got kind=%0d val=0x%0h expected kind=%0d val=0x%0h",
                             dataDone, dataDone ? dataReadData : instructionData,
                             mon_e.is_data, mon_e.val);
                end
            end
        end
        if (memWriteEnable) chk("we_inside_request", {63'd0, memRequest}, 64'd1);
    end

    task automatic run_fetch(input logic [31:0] a, output int req_cycles, output logic [31:0] first_addr);
        int n = 0;
        req_cycles = 0;
        first_addr = '0;
        instructionRequest = 1'b1;
        instructionAddress = a;
        do begin
            @(negedge clk);
            n++;
            if (memRequest) begin
                if (req_cycles == 0) first_addr = memAddress;
                req_cycles++;
            end
        end while (!instructionSuccess && n < 100);
        if (n >= 100) chk("fetch_timeout", 64'd1, 64'd0);
        instructionRequest = 1'b0;
    endtask

    task automatic run_data(input logic wr, input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        dataRead      = !wr;
        dataWrite     = wr;
        dataAddress   = a;
        dataWriteData = wd;
        do begin
            @(negedge clk);
            n++;
        end while (!dataDone && n < 100);
        if (n >= 100) chk("data_timeout", 64'd1, 64'd0);
        dataRead  = 1'b0;
        dataWrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int          rc;
        int          n;
        int          pulses;
        logic [31:0] fa;
        int          rc2;
        logic [31:0] fa2;

        mem[32'h40]   = 32'h0050_0093;
        mem[32'h44]   = 32'h1234_5678;
        mem[32'h48]   = 32'h4444_4444;
        mem[32'h80]   = 32'h0BAD_F00D;
        mem[32'h84]   = 32'h00A0_0113;
        mem[32'h2000] = 32'hCAFE_0001;
        mem[32'h3000] = 32'h3333_3333;

        repeat (3) @(negedge clk);
        chk("rst_memRequest", {63'd0, memRequest}, 64'd0);
        chk("rst_memAddress", {32'd0, memAddress}, 64'd0);
        chk("rst_instructionData", {32'd0, instructionData}, 64'd0);
        chk("rst_dataReadData", {32'd0, dataReadData}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Fetch only, memReady in the third request cycle
        wait_cycles = 2;
        push_exp(1'b0, 32'h0050_0093);
        run_fetch(32'h40, rc, fa);
        chk("fetch_req_cycles", 64'(rc), 64'd3);
        chk("fetch_memAddress", {32'd0, fa}, 64'h40);
        chk("fetch_instructionData", {32'd0, instructionData}, 64'h0050_0093);

        // Contested, zero-wait: data first
        wait_cycles = 0;
        push_exp(1'b1, 32'hCAFE_0001);
        push_exp(1'b0, 32'h1234_5678);
        fork
            run_data(1'b0, 32'h2000, 32'h0);
            run_fetch(32'h44, rc2, fa2);
        join
        chk("contest_dataReadData", {32'd0, dataReadData}, 64'hCAFE_0001);
        chk("contest_instructionData", {32'd0, instructionData}, 64'h1234_5678);

        // Store leaves dataReadData alone
        push_exp(1'b1, 32'hCAFE_0001);
        run_data(1'b1, 32'h1000, 32'hDEAD_BEEF);
        chk("store_backend_written", {32'd0, mem[32'h1000]}, 64'hDEAD_BEEF);
        push_exp(1'b1, 32'hDEAD_BEEF);
        run_data(1'b0, 32'h1000, 32'h0);

        // Flush during INSTR_WAIT
        wait_cycles = 2;
        @(negedge clk);
        instructionRequest = 1'b1;
        instructionAddress = 32'h80;
        n = 0;
        do begin @(negedge clk); n++; end while (!memRequest && n < 20);
        chk("flush_request_seen", {63'd0, memRequest}, 64'd1);
        instructionFlush   = 1'b1;
        instructionRequest = 1'b0;
        @(negedge clk);
        instructionFlush = 1'b0;
        repeat (6) @(negedge clk);
        chk("flush_memRequest_done", {63'd0, memRequest}, 64'd0);
        chk("flush_instructionData_kept", {32'd0, instructionData}, 64'h1234_5678);
        push_exp(1'b0, 32'h00A0_0113);
        run_fetch(32'h84, rc, fa);
        chk("after_flush_instructionData", {32'd0, instructionData}, 64'h00A0_0113);

        // Continuous contention: grant order
        wait_cycles = 0;
`ifdef ARBITER_STARVATION_GUARD_EN
        push_exp(1'b1, 32'h3333_3333); push_exp(1'b1, 32'h3333_3333); push_exp(1'b0, 32'h4444_4444);
        push_exp(1'b1, 32'h3333_3333); push_exp(1'b1, 32'h3333_3333); push_exp(1'b0, 32'h4444_4444);
`else
        for (int i = 0; i < 6; i++) push_exp(1'b1, 32'h3333_3333);
`endif
        @(negedge clk);
        dataRead           = 1'b1;
        dataAddress        = 32'h3000;
        instructionRequest = 1'b1;
        instructionAddress = 32'h48;
        n = 0;
        pulses = 0;
        while (pulses < 6 && n < 200) begin
            @(negedge clk);
            n++;
            if (instructionSuccess || dataDone) pulses++;
        end
        dataRead           = 1'b0;
        instructionRequest = 1'b0;
        chk("burst_pulses", 64'(pulses), 64'd6);

        // Reset while in DATA_WAIT
        wait_cycles = 5;
        @(negedge clk);
        dataRead    = 1'b1;
        dataAddress = 32'h2000;
        n = 0;
        do begin @(negedge clk); n++; end while (!memRequest && n < 20);
        chk("rst_mid_request_seen", {63'd0, memRequest}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_memRequest", {63'd0, memRequest}, 64'd0);
        chk("rst_mid_dataReadData", {32'd0, dataReadData}, 64'd0);
        chk("rst_mid_instructionData", {32'd0, instructionData}, 64'd0);
        chk("rst_mid_memAddress", {32'd0, memAddress}, 64'd0);
        dataRead = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", {63'd0, memRequest}, 64'd0);
        wait_cycles = 0;
        push_exp(1'b0, 32'h0050_0093);
        run_fetch(32'h40, rc, fa);
        chk("post_rst_fetch_cycles", 64'(rc), 64'd1);

        repeat (4) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
